// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_pkg                                                            |
// | Load/store size codes, channel state type and load extension.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mem_pkg;

   localparam logic [2:0] MEM_B  = 3'd0;
   localparam logic [2:0] MEM_H  = 3'd1;
   localparam logic [2:0] MEM_W  = 3'd2;
   localparam logic [2:0] MEM_D  = 3'd3;
   localparam logic [2:0] MEM_BU = 3'd4;
   localparam logic [2:0] MEM_HU = 3'd5;
   localparam logic [2:0] MEM_WU = 3'd6;

   typedef enum logic [0:0] {
      CH_IDLE = 1'b0,
      CH_BUSY = 1'b1
   } ch_state_e;

   function automatic logic [63:0] extend(input logic [63:0] raw, input logic [2:0] f3);
      logic [63:0] v;
      case (f3)
         MEM_B:   v = {{56{raw[7]}},  raw[7:0]};
         MEM_H:   v = {{48{raw[15]}}, raw[15:0]};
         MEM_W:   v = {{32{raw[31]}}, raw[31:0]};
         MEM_D:   v = raw;
         MEM_BU:  v = {56'd0, raw[7:0]};
         MEM_HU:  v = {48'd0, raw[15:0]};
         MEM_WU:  v = {32'd0, raw[31:0]};
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder_if                                                   |
// | Icache fetch, dcache load and dcache store request/done channels. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mem_responder_if;

   logic        icache_rqst;
   logic [63:0] icache_addr;
   logic        icache_done;
   logic [63:0] icache_data;

   logic        dcache_r_rqst;
   logic [63:0] dcache_r_addr;
   logic [2:0]  dcache_r_bits;
   logic        dcache_r_done;
   logic [63:0] dcache_r_data;

   logic        dcache_w_rqst;
   logic [63:0] dcache_w_addr;
   logic [2:0]  dcache_w_bits;
   logic [63:0] dcache_w_data;
   logic        dcache_w_done;

   modport master (
      output icache_rqst, icache_addr,
      input  icache_done, icache_data,
      output dcache_r_rqst, dcache_r_addr, dcache_r_bits,
      input  dcache_r_done, dcache_r_data,
      output dcache_w_rqst, dcache_w_addr, dcache_w_bits, dcache_w_data,
      input  dcache_w_done
   );

   modport slave (
      input  icache_rqst, icache_addr,
      output icache_done, icache_data,
      input  dcache_r_rqst, dcache_r_addr, dcache_r_bits,
      output dcache_r_done, dcache_r_data,
      input  dcache_w_rqst, dcache_w_addr, dcache_w_bits, dcache_w_data,
      output dcache_w_done
   );

endinterface
`default_nettype wire

// File: rtl/mem_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_channel                                                        |
// | IDLE/BUSY latency sequencer producing capture, fire and done.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_channel
   import mem_pkg::*;
#(
   parameter int LAT = 1
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_rqst,
   output logic      o_cap,
   output logic      o_fire,
   output logic      o_done
);

   localparam int            CW    = (LAT > 2) ? $clog2(LAT - 1) : 1;
   localparam bit            MULTI = (LAT > 1);
   localparam logic [CW-1:0] LOAD  = CW'((LAT > 1) ? (LAT - 2) : 0);

   ch_state_e     r_state;
   logic [CW-1:0] r_cnt;
   logic          r_done;
   logic          w_cap;
   logic          w_fire;

   // o_fire marks the edge that raises done; with LAT=1 that is the capture edge itself.
   assign w_cap  = rst && (r_state == CH_IDLE) && i_rqst;
   assign w_fire = MULTI ? (rst && (r_state == CH_BUSY) && (r_cnt == '0)) : w_cap;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= CH_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_fire;
         case (r_state)
            CH_IDLE: begin
               if (w_cap && MULTI) begin
                  r_state <= CH_BUSY;
                  r_cnt   <= LOAD;
               end
            end
            CH_BUSY: begin
               if (r_cnt == '0) begin
                  r_state <= CH_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= CH_IDLE;
         endcase
      end
   end

   assign o_cap  = w_cap;
   assign o_fire = w_fire;
   assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_responder                                                      |
// | Latency-controlled byte memory answering icache/dcache channels.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_responder
    import mem_pkg::*;
#(
    parameter int AW        = 16,
    parameter int I_LAT     = 1,
    parameter int R_LAT     = 2,
    parameter int W_LAT     = 2,
    parameter     INIT_FILE = ""
) (
    input wire logic         clk,
    input wire logic         rst,
    mem_responder_if.slave   bus
);

    logic [7:0]    r_mem [0:(1<<AW)-1];

    logic          w_i_cap, w_i_fire, w_i_done;
    logic          w_r_cap, w_r_fire, w_r_done;
    logic          w_w_cap, w_w_fire, w_w_done;

    logic [AW-1:0] r_i_addr, r_r_addr, r_w_addr;
    logic [2:0]    r_r_bits, r_w_bits;
    logic [63:0]   r_w_data;
    logic [63:0]   r_i_data, r_r_data;

    logic [AW-1:0] w_i_addr, w_r_addr, w_w_addr;
    logic [2:0]    w_r_bits, w_w_bits;
    logic [63:0]   w_w_data;
    logic [63:0]   w_i_raw, w_r_raw;
    logic [7:0]    w_w_be;

    wire logic w_unused = ^{bus.icache_addr[63:AW], bus.dcache_r_addr[63:AW],
                            bus.dcache_w_addr[63:AW]};

    mem_channel #(.LAT(I_LAT)) u_ich (
        .clk(clk), .rst(rst), .i_rqst(bus.icache_rqst),
        .o_cap(w_i_cap), .o_fire(w_i_fire), .o_done(w_i_done)
    );

    mem_channel #(.LAT(R_LAT)) u_rch (
        .clk(clk), .rst(rst), .i_rqst(bus.dcache_r_rqst),
        .o_cap(w_r_cap), .o_fire(w_r_fire), .o_done(w_r_done)
    );

    mem_channel #(.LAT(W_LAT)) u_wch (
        .clk(clk), .rst(rst), .i_rqst(bus.dcache_w_rqst),
        .o_cap(w_w_cap), .o_fire(w_w_fire), .o_done(w_w_done)
    );

    // Bypass the capture registers when a channel captures and fires on the same edge.
    assign w_i_addr = w_i_cap ? bus.icache_addr[AW-1:0]   : r_i_addr;
    assign w_r_addr = w_r_cap ? bus.dcache_r_addr[AW-1:0] : r_r_addr;
    assign w_r_bits = w_r_cap ? bus.dcache_r_bits         : r_r_bits;
    assign w_w_addr = w_w_cap ? bus.dcache_w_addr[AW-1:0] : r_w_addr;
    assign w_w_bits = w_w_cap ? bus.dcache_w_bits         : r_w_bits;
    assign w_w_data = w_w_cap ? bus.dcache_w_data         : r_w_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_addr <= '0;
            r_r_addr <= '0;
            r_r_bits <= '0;
            r_w_addr <= '0;
            r_w_bits <= '0;
            r_w_data <= '0;
        end else begin
            if (w_i_cap) r_i_addr <= bus.icache_addr[AW-1:0];
            if (w_r_cap) begin
                r_r_addr <= bus.dcache_r_addr[AW-1:0];
                r_r_bits <= bus.dcache_r_bits;
            end
            if (w_w_cap) begin
                r_w_addr <= bus.dcache_w_addr[AW-1:0];
                r_w_bits <= bus.dcache_w_bits;
                r_w_data <= bus.dcache_w_data;
            end
        end
    end

    // Address sums are AW bits wide, so multi-byte accesses wrap around the array.
    always_comb begin
        w_i_raw = '0;
        w_r_raw = '0;
        for (int i = 0; i < 8; i++) begin
            w_i_raw[i*8 +: 8] = r_mem[w_i_addr + AW'(i)];
            w_r_raw[i*8 +: 8] = r_mem[w_r_addr + AW'(i)];
        end
    end

    always_comb begin
        w_w_be = 8'h00;
        if (!w_w_bits[2]) begin
            case (w_w_bits[1:0])
                2'd0:    w_w_be = 8'h01;
                2'd1:    w_w_be = 8'h03;
                2'd2:    w_w_be = 8'h0F;
                default: w_w_be = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_fire) begin
            for (int i = 0; i < 8; i++) begin
                if (w_w_be[i]) r_mem[w_w_addr + AW'(i)] <= w_w_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_data <= '0;
            r_r_data <= '0;
        end else begin
            if (w_i_fire) r_i_data <= w_i_raw;
            if (w_r_fire) r_r_data <= extend(w_r_raw, w_r_bits);
        end
    end

    assign bus.icache_done   = w_i_done;
    assign bus.icache_data   = r_i_data;
    assign bus.dcache_r_done = w_r_done;
    assign bus.dcache_r_data = r_r_data;
    assign bus.dcache_w_done = w_w_done;

endmodule
`default_nettype wire
